beaten_pix_filter: RTL and testbench
====================================

Name: beaten_pix_filter

Overview:
- Parametrised successor to the two-channel beaten-pixel corrector for the thermal imager ADC path.
- Sits between the ADC capture registers and frame buffering.
- Replaces "beaten" (dead/spiking) pixels with the last accepted neighbour value.
- Adds the following:
  - N channels and generic width.
  - Valid-qualified pipeline.
  - Line/frame awareness.
  - Forced acceptance after a run of rejects, so real scene edges cannot lock the filter.
  - Per-frame replaced-pixel statistics.

Parameters:
ADC_WIDTH, 14, sample width in bits (unsigned)
CHANNELS, 2, pixels delivered per input beat; spatial order ch0 first
MAX_REJECT, 3, consecutive replacements allowed before next pixel is force-accepted (>=1)
CNT_WIDTH, 16, width of replaced-pixel frame counter

Ports:
CLK  in  1  system clock; single clock domain
RST  in  1  asynchronous reset, active-high
ENABLE  in  1  1 = filter active, 0 = bypass
IN_VALID  in  1  input beat valid; may be high every cycle
IN_DATA  in  CHANNELS*ADC_WIDTH  ch k at bits [k*ADC_WIDTH +: ADC_WIDTH]
LINE_START  in  1  qualified by IN_VALID; beat is first of a line
FRAME_START  in  1  qualified by IN_VALID; beat is first of a frame
LEVEL  in  ADC_WIDTH  reject threshold; sampled with each beat
OUT_VALID  out  1  output beat valid
OUT_DATA  out  CHANNELS*ADC_WIDTH  corrected pixels, same packing
OUT_BEAT  out  CHANNELS  per-channel 1 = pixel was replaced
BEAT_COUNT  out  CNT_WIDTH  replaced-pixel total of the previous completed frame

Behaviour:
- Reset (async, RST=1):
  - OUT_VALID, OUT_DATA, OUT_BEAT and BEAT_COUNT = 0.
  - ref = 0, ref_valid = 0, reject counter = 0, frame counter = 0, pipeline valids = 0.
- Latency: fixed 2 cycles, IN_VALID to OUT_VALID; full throughput, one beat per cycle.
  - Stage 1 registers IN_DATA, LEVEL, ENABLE and the flags.
  - Stage 2 evaluates the channel chain and registers outputs.
- IN_VALID=0: no state change.
  - OUT_VALID=0 two cycles later.
  - OUT_DATA and OUT_BEAT hold their last values.
- Chain per beat, k = 0..CHANNELS-1, evaluated serially in channel order:
  - diff = |x_k - ref|, computed as larger minus smaller in ADC_WIDTH bits; never wraps.
  - Force-accept if any of: ref_valid=0; k=0 on a LINE_START beat; reject counter == MAX_REJECT; LEVEL == 0.
  - Otherwise accept iff diff < LEVEL.
  - Accept: out_k = x_k, ref = x_k, reject counter = 0, OUT_BEAT[k] = 0.
  - Reject: out_k = ref (ref unchanged), reject counter +1, OUT_BEAT[k] = 1.
  - ch k+1 compares against ref as updated by ch k in the same beat.
  - ref, ref_valid and the reject counter persist across beats.
- LINE_START: ch0 is force-accepted and the reject counter is cleared before ch0 is evaluated.
- Frame counter:
  - Adds popcount(OUT_BEAT) each valid beat; saturates at 2^CNT_WIDTH-1.
  - On a FRAME_START beat, BEAT_COUNT takes the counter value accumulated before this beat.
  - The counter then restarts with this beat's popcount.
  - FRAME_START also implies LINE_START behaviour.
- Bypass (ENABLE=0 at stage 1 of a beat):
  - OUT_DATA = IN_DATA with the same 2-cycle latency; OUT_BEAT = 0.
  - ref follows the raw last channel; ref_valid = 1; reject counter = 0.
  - Frame counter is not incremented, but FRAME_START latching still occurs.
- ENABLE toggling mid-line takes effect per beat; no flush and no bubble.
- RST asserted mid-frame: all state cleared immediately; in-flight beats discarded (OUT_VALID low).

Decomposition:
- Shared package/define file:
  - ADC_WIDTH default.
  - MODE bit index for filter enable, driven from MODE_FPGA upstream.
  - Default LEVEL constant.
- Sub-module beaten_pix_cell, combinational, one channel decision.
  - Inputs: x, ref, LEVEL, force.
  - Outputs: out, new_ref, beat.
  - Instantiated CHANNELS times in a generate chain; top holds registers, counters and the frame logic.

Test Plan:
- Reset then beat {ch0=100, ch1=102}, LEVEL=10, LINE_START=1 -> 2 cycles later OUT_DATA {100,102}, OUT_BEAT=00.
- Next beat {105, 900}, LEVEL=10 -> out {105,105}, OUT_BEAT=10 (ch1 replaced, bit1); following beat {108,110} -> {108,110}, OUT_BEAT=00.
- Scene edge, MAX_REJECT=3, ref=100, LEVEL=10, beats {500,500},{500,500} -> ch0,ch1,ch0 replaced with 100; 4th pixel force-accepted as 500, then all accepted.
- Threshold boundary, ref=100, LEVEL=10 -> x=109 and x=91 accepted, x=110 and x=90 replaced; LEVEL=0 -> x=16383 accepted; x=0 vs ref=16383 -> diff 16383, no wrap.
- Frame stats: 7 replaced pixels across a frame, then FRAME_START beat with 1 replacement -> BEAT_COUNT=7 at that beat's output; next FRAME_START with no further replacements -> BEAT_COUNT=1; preload near saturation -> holds at 65535.
- ENABLE=0 with spiky data {0,16383} -> passthrough, OUT_BEAT=00, counter unchanged; RST pulse between two valid beats -> OUT_VALID low, all outputs 0, next pixel force-accepted.

Source files
------------

// File: rtl/beaten_pix_filter_pkg.sv
// Shared constants for the beaten-pixel filter: default widths, mode bit and threshold.
package beaten_pix_filter_pkg;

  localparam int unsigned ADC_WIDTH_DEF  = 14;
  localparam int unsigned CHANNELS_DEF   = 2;
  localparam int unsigned MAX_REJECT_DEF = 3;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

  // Bit of the upstream MODE_FPGA register that drives ENABLE
  localparam int unsigned MODE_FILTER_EN_BIT = 0;

  localparam logic [ADC_WIDTH_DEF-1:0] LEVEL_DEF = ADC_WIDTH_DEF'(64);

endpackage

// File: rtl/beaten_pix_cell.sv
// One channel decision: accept the sample or replace it with the running reference.
module beaten_pix_cell
  import beaten_pix_filter_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = ADC_WIDTH_DEF
) (
  input  logic [ADC_WIDTH-1:0] x,
  input  logic [ADC_WIDTH-1:0] ref_val,
  input  logic [ADC_WIDTH-1:0] level,
  input  logic                 force_acc,
  output logic [ADC_WIDTH-1:0] pix_c,
  output logic [ADC_WIDTH-1:0] new_ref_c,
  output logic                 beat_c
);

  logic [ADC_WIDTH-1:0] diff;
  logic                 accept;

  // Larger minus smaller so the distance never wraps
  always_comb begin
    diff      = (x >= ref_val) ? (x - ref_val) : (ref_val - x);
    accept    = force_acc || (diff < level);
    pix_c     = accept ? x : ref_val;
    new_ref_c = pix_c;
    beat_c    = !accept;
  end

endmodule

// File: rtl/beaten_pix_filter.sv
// N-channel beaten-pixel corrector: two-stage valid pipeline, reject chain and per-frame stats.
module beaten_pix_filter
  import beaten_pix_filter_pkg::*;
#(
  parameter int unsigned ADC_WIDTH  = ADC_WIDTH_DEF,
  parameter int unsigned CHANNELS   = CHANNELS_DEF,
  parameter int unsigned MAX_REJECT = MAX_REJECT_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          ENABLE,
  input  logic                          IN_VALID,
  input  logic [CHANNELS*ADC_WIDTH-1:0] IN_DATA,
  input  logic                          LINE_START,
  input  logic                          FRAME_START,
  input  logic [ADC_WIDTH-1:0]          LEVEL,
  output logic                          OUT_VALID,
  output logic [CHANNELS*ADC_WIDTH-1:0] OUT_DATA,
  output logic [CHANNELS-1:0]           OUT_BEAT,
  output logic [CNT_WIDTH-1:0]          BEAT_COUNT
);

  localparam int unsigned DW = CHANNELS * ADC_WIDTH;
  localparam int unsigned RW = $clog2(MAX_REJECT + 1);
  localparam int unsigned PW = $clog2(CHANNELS + 1);
  localparam int unsigned SW = CNT_WIDTH + 1;

  logic                 s1_valid, s1_enable, s1_line, s1_frame;
  logic [DW-1:0]        s1_data;
  logic [ADC_WIDTH-1:0] s1_level;

  logic [ADC_WIDTH-1:0] ref_q;
  logic                 ref_valid_q;
  logic [RW-1:0]        rej_q;
  logic [CNT_WIDTH-1:0] frame_cnt;

  logic [DW-1:0]        filt_data;
  logic [CHANNELS-1:0]  filt_beat;
  logic [PW-1:0]        pop;
  logic [SW-1:0]        cnt_sum;
  logic [CNT_WIDTH-1:0] cnt_next;

  // Stage 1: capture the beat; FRAME_START carries LINE_START behaviour
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_level  <= '0;
      s1_enable <= 1'b0;
      s1_line   <= 1'b0;
      s1_frame  <= 1'b0;
    end else begin
      s1_valid <= IN_VALID;
      if (IN_VALID) begin
        s1_data   <= IN_DATA;
        s1_level  <= LEVEL;
        s1_enable <= ENABLE;
        s1_line   <= LINE_START | FRAME_START;
        s1_frame  <= FRAME_START;
      end
    end
  end

  // Serial channel chain: each channel sees the reference left by the previous one
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [ADC_WIDTH-1:0] ref_in, new_ref, pix;
    logic [RW-1:0]        rej_in, rej_out;
    logic                 force_acc, beat;

    if (k == 0) begin : g_first
      assign ref_in    = ref_q;
      assign rej_in    = s1_line ? '0 : rej_q;
      assign force_acc = !ref_valid_q || s1_line || (rej_in == RW'(MAX_REJECT)) ||
                         (s1_level == '0);
    end else begin : g_next
      assign ref_in    = g_ch[k-1].new_ref;
      assign rej_in    = g_ch[k-1].rej_out;
      assign force_acc = (rej_in == RW'(MAX_REJECT)) || (s1_level == '0);
    end

    assign rej_out = beat ? (rej_in + RW'(1)) : '0;

    beaten_pix_cell #(.ADC_WIDTH(ADC_WIDTH)) u_cell (
      .x         (s1_data[k*ADC_WIDTH +: ADC_WIDTH]),
      .ref_val   (ref_in),
      .level     (s1_level),
      .force_acc (force_acc),
      .pix_c     (pix),
      .new_ref_c (new_ref),
      .beat_c    (beat)
    );

    assign filt_data[k*ADC_WIDTH +: ADC_WIDTH] = pix;
    assign filt_beat[k]                        = beat;
  end

  // Replaced-pixel count for this beat and saturating frame accumulation
  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      pop = pop + PW'(filt_beat[i]);
    end
    cnt_sum  = {1'b0, frame_cnt} + SW'(pop);
    cnt_next = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
  end

  // Stage 2: commit chain results, reference state and frame statistics
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_VALID   <= 1'b0;
      OUT_DATA    <= '0;
      OUT_BEAT    <= '0;
      BEAT_COUNT  <= '0;
      ref_q       <= '0;
      ref_valid_q <= 1'b0;
      rej_q       <= '0;
      frame_cnt   <= '0;
    end else begin
      OUT_VALID <= s1_valid;
      if (s1_valid) begin
        ref_valid_q <= 1'b1;
        if (s1_enable) begin
          OUT_DATA <= filt_data;
          OUT_BEAT <= filt_beat;
          ref_q    <= g_ch[CHANNELS-1].new_ref;
          rej_q    <= g_ch[CHANNELS-1].rej_out;
        end else begin
          OUT_DATA <= s1_data;
          OUT_BEAT <= '0;
          ref_q    <= s1_data[DW-1 -: ADC_WIDTH];
          rej_q    <= '0;
        end
        if (s1_frame) begin
          BEAT_COUNT <= frame_cnt;
          frame_cnt  <= s1_enable ? CNT_WIDTH'(pop) : '0;
        end else if (s1_enable) begin
          frame_cnt <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_beaten_pix_filter.sv
// Randomised and directed bench for beaten_pix_filter against a per-pixel reference model.
module tb_beaten_pix_filter;
  import beaten_pix_filter_pkg::*;

  localparam int unsigned W    = 14;
  localparam int unsigned CH   = 2;
  localparam int          MAXR = 3;
  localparam int          CAP  = 65535;
  localparam int          CAPS = 15;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            ENABLE = 1'b0;
  logic            IN_VALID = 1'b0;
  logic [CH*W-1:0] IN_DATA = '0;
  logic            LINE_START = 1'b0;
  logic            FRAME_START = 1'b0;
  logic [W-1:0]    LEVEL = '0;

  logic            OUT_VALID, OUT_VALID_S;
  logic [CH*W-1:0] OUT_DATA, OUT_DATA_S;
  logic [CH-1:0]   OUT_BEAT, OUT_BEAT_S;
  logic [15:0]     BEAT_COUNT;
  logic [3:0]      BEAT_COUNT_S;

  beaten_pix_filter dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START), .LEVEL(LEVEL),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_BEAT(OUT_BEAT), .BEAT_COUNT(BEAT_COUNT)
  );

  beaten_pix_filter #(.CNT_WIDTH(4)) dut_sat (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START), .LEVEL(LEVEL),
    .OUT_VALID(OUT_VALID_S), .OUT_DATA(OUT_DATA_S), .OUT_BEAT(OUT_BEAT_S),
    .BEAT_COUNT(BEAT_COUNT_S)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic            v;
    logic [CH*W-1:0] d;
    logic [CH-1:0]   b;
    logic [31:0]     bc;
  } exp_t;

  exp_t pipe[$];
  int   total = 0;
  int   bad = 0;

  int            m_ref, m_rv, m_rej, m_tot, m_bc;
  logic [CH*W-1:0] m_d;
  logic [CH-1:0]   m_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CH*W-1:0] px(input int c0, input int c1);
    return {W'(c1), W'(c0)};
  endfunction

  task automatic model_reset();
    m_ref = 0; m_rv = 0; m_rej = 0; m_tot = 0; m_bc = 0;
    m_d = '0; m_b = '0;
  endtask

  // Spec rules applied pixel by pixel with plain integers
  task automatic model_step(input logic [CH*W-1:0] d, input bit ls, input bit fs,
                            input int lvl, input bit en);
    bit line;
    int pop, x, diff;
    line = ls | fs;
    pop  = 0;
    m_b  = '0;
    if (!en) begin
      m_d   = d;
      m_ref = int'(d[(CH-1)*W +: W]);
      m_rv  = 1;
      m_rej = 0;
    end else begin
      if (line) m_rej = 0;
      for (int k = 0; k < int'(CH); k++) begin
        x    = int'(d[k*W +: W]);
        diff = (x > m_ref) ? x - m_ref : m_ref - x;
        if (m_rv == 0 || (k == 0 && line) || m_rej == MAXR || lvl == 0 || diff < lvl) begin
          m_d[k*W +: W] = W'(x);
          m_ref = x;
          m_rv  = 1;
          m_rej = 0;
        end else begin
          m_d[k*W +: W] = W'(m_ref);
          m_b[k] = 1'b1;
          m_rej++;
          pop++;
        end
      end
    end
    if (fs) begin
      m_bc  = m_tot;
      m_tot = pop;
    end else begin
      m_tot += pop;
    end
  endtask

  task automatic beat(input bit v, input logic [CH*W-1:0] d, input bit ls, input bit fs,
                      input int lvl, input bit en);
    exp_t e;
    IN_VALID = v; IN_DATA = d; LINE_START = ls; FRAME_START = fs;
    LEVEL = W'(lvl); ENABLE = en;
    if (v) model_step(d, ls, fs, lvl, en);
    e.v = v; e.d = m_d; e.b = m_b; e.bc = 32'(m_bc);
    pipe.push_back(e);
    @(posedge CLK); #1;
    if (pipe.size() >= 2) begin
      e = pipe.pop_front();
      chk("out_valid", 64'(OUT_VALID), 64'(e.v));
      chk("out_data", 64'(OUT_DATA), 64'(e.d));
      chk("out_beat", 64'(OUT_BEAT), 64'(e.b));
      chk("beat_count", 64'(BEAT_COUNT), 64'((e.bc > CAP) ? CAP : e.bc));
      chk("beat_count_sat", 64'(BEAT_COUNT_S), 64'((e.bc > CAPS) ? CAPS : e.bc));
      chk("sat_inst_data", 64'(OUT_DATA_S), 64'(e.d));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, '0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic do_reset();
    IN_VALID = 1'b0;
    RST = 1'b1;
    #1;
    chk("rst_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_data", 64'(OUT_DATA), 64'd0);
    chk("rst_beat", 64'(OUT_BEAT), 64'd0);
    chk("rst_count", 64'(BEAT_COUNT), 64'd0);
    pipe.delete();
    model_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    int base, lvl, x0, x1;
    logic [3:0] mode;
    model_reset();
    #2;
    do_reset();

    // Basic acceptance and a single spike
    beat(1, px(100, 102), 1, 0, 10, 1);
    beat(1, px(105, 900), 0, 0, 10, 1);
    beat(1, px(108, 110), 0, 0, 10, 1);
    // Scene edge: three replacements then forced acceptance
    beat(1, px(100, 100), 1, 0, 10, 1);
    beat(1, px(500, 500), 0, 0, 10, 1);
    beat(1, px(500, 500), 0, 0, 10, 1);
    beat(1, px(500, 500), 0, 0, 10, 1);
    // Threshold boundaries against ref=100, LEVEL=0, and no-wrap distance
    beat(1, px(100, 109), 1, 0, 10, 1);
    beat(1, px(100, 91), 1, 0, 10, 1);
    beat(1, px(100, 110), 1, 0, 10, 1);
    beat(1, px(100, 90), 1, 0, 10, 1);
    beat(1, px(0, 16383), 0, 0, 0, 1);
    beat(1, px(16383, 0), 1, 0, 16383, 1);
    // Frame stats: 7 replacements, then a frame start with 1, then one with none
    beat(1, px(100, 100), 1, 1, 10, 1);
    beat(1, px(900, 900), 0, 0, 10, 1);
    beat(1, px(900, 100), 0, 0, 10, 1);
    beat(1, px(900, 900), 0, 0, 10, 1);
    beat(1, px(900, 100), 0, 0, 10, 1);
    beat(1, px(100, 900), 0, 0, 10, 1);
    beat(1, px(900, 100), 1, 1, 10, 1);
    beat(1, px(900, 900), 0, 0, 10, 1);
    beat(1, px(900, 900), 0, 1, 10, 1);
    // Enough replacements to saturate the narrow counter instance
    for (int i = 0; i < 12; i++) begin
      beat(1, px(3000, 3000), 0, 0, 1, 1);
      beat(1, px(3000, 3000), 0, 0, 1, 1);
      beat(1, px(200, 200), 0, 0, 1, 1);
      beat(1, px(200, 200), 0, 0, 1, 1);
    end
    beat(1, px(200, 200), 0, 1, 1, 1);
    beat(1, px(200, 200), 0, 1, 1, 1);
    // Bypass with spiky data, then re-enable mid-line
    beat(1, px(0, 16383), 0, 0, 10, 0);
    beat(1, px(16383, 0), 0, 0, 10, 0);
    beat(1, px(5, 16383), 0, 1, 10, 0);
    beat(1, px(16380, 3), 0, 0, 10, 1);
    beat(1, px(7, 7), 0, 1, 10, 1);
    // Reset between valid beats discards in-flight data
    beat(1, px(1000, 1001), 0, 0, 10, 1);
    do_reset();
    beat(1, px(5000, 5001), 0, 0, 10, 1);
    beat(1, px(7000, 5002), 0, 0, 10, 1);
    idle(2);

    // Random traffic
    base = 8000;
    mode = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) base = int'($urandom_range(0, 16383));
      x0 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 16383))
                                      : base + int'($urandom_range(0, 30)) - 15;
      x1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 16383))
                                      : base + int'($urandom_range(0, 30)) - 15;
      if (x0 < 0) x0 = 0;
      if (x0 > 16383) x0 = 16383;
      if (x1 < 0) x1 = 0;
      if (x1 > 16383) x1 = 16383;
      case ($urandom_range(0, 4))
        0:       lvl = 0;
        1:       lvl = 10;
        2:       lvl = 20;
        3:       lvl = int'(LEVEL_DEF);
        default: lvl = 16383;
      endcase
      mode[MODE_FILTER_EN_BIT] = ($urandom_range(0, 99) < 85);
      beat($urandom_range(0, 9) < 8, px(x0, x1), $urandom_range(0, 9) == 0,
           $urandom_range(0, 49) == 0, lvl, mode[MODE_FILTER_EN_BIT]);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
